rv_fetch_queue: RTL
===================

Name: rv_fetch_queue

Overview:
- Parametrised instruction-fetch front end that replaces the single-register IF stage of the RV32E pipeline.
- Issues sequential fetches to a variable-latency instruction memory over a valid/ready request channel and an in-order response channel.
- Buffers up to DEPTH instructions with their PCs and presents them to ID over a valid/ready handshake.
- Supports redirect (branch/flush) with discard of in-flight responses.

Parameters:
- XLEN, 32, address/instruction width.
- DEPTH, 4, queue entries; power of two, >=2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- redirect  in  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (forced 0).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address.
- imem_rsp_valid  in  1  response valid; responses return in request order, always accepted.
- imem_rsp_data  in  XLEN  fetched instruction.
- out_valid  out  1  head entry holds a valid instruction.
- out_ready  in  1  ID consumes the head entry.
- out_pc  out  XLEN  PC of the head entry.
- out_instr  out  XLEN  instruction of the head entry.
- occupancy  out  $clog2(DEPTH)+1  allocated entries, filled or pending.

Behaviour:
- Entries are allocated at request issue, not at response. Each entry holds pc, instr and a filled bit. Pointers are alloc_ptr, fill_ptr and head_ptr, each $clog2(DEPTH)+1 bits; wrap uses the MSB.
- Reset (reset=0, async):
  - fetch_pc=RESET_PC; all pointers=0; discard_cnt=0.
  - Outputs during reset: imem_req_valid=0, out_valid=0, out_pc=0, out_instr=0, occupancy=0.
- Issue: imem_req_valid = reset_n && !redirect && occupancy<DEPTH, with imem_req_addr=fetch_pc.
  - On handshake: write fetch_pc to entry[alloc_ptr], clear its filled bit, alloc_ptr++, fetch_pc+=4 (wraps modulo 2^XLEN).
  - imem_req_valid must stay asserted and addr must stay stable until accepted, unless redirect occurs.
- Response: if discard_cnt>0, drop the response and discard_cnt--. Otherwise write data to entry[fill_ptr], set filled, fill_ptr++.
  - A response with no pending entry and discard_cnt=0 is a protocol error; ignore it (assertion in sim).
- Output: out_valid = entry[head_ptr].filled && occupancy>0, combinational from registered state.
  - Min latency: response in cycle N gives out_valid in cycle N+1. Request accepted in N with 1-cycle memory gives out_valid in N+2.
  - On out_valid && out_ready: head_ptr++.
- occupancy = alloc_ptr - head_ptr.
- Simultaneous issue and dequeue when full: issue uses occupancy before dequeue, so no issue that cycle (registered credit, no bypass).
- Redirect (highest priority, single cycle):
  - head_ptr, fill_ptr and alloc_ptr reset to 0; fetch_pc=redirect_pc & ~3.
  - discard_cnt += (alloc_ptr - fill_ptr) of the pre-redirect state, minus 1 if a non-discarded response arrives in the same cycle; that response is itself dropped.
  - Any handshake in the redirect cycle is suppressed because req_valid=0.
  - out_valid is forced 0 in the redirect cycle; an out_ready in that cycle does not consume.
  - First new request issues the cycle after redirect.
- Back-to-back redirects accumulate discard_cnt. Width is $clog2(DEPTH)+2 bits, and it saturates at DEPTH*2 (sim assertion if exceeded).
- Responses arriving while discard_cnt>0 after redirect are dropped before any new response is stored. In-order delivery guarantees this is correct.

Optional Feature:
- Macro FETCH_QUEUE_STATS_EN.
- Defined: adds outputs stat_stall_cycles [31:0], stat_discarded [31:0] and stat_redirects [31:0].
  - stat_stall_cycles increments on cycles with occupancy==DEPTH.
  - stat_discarded increments per dropped response.
  - stat_redirects increments per redirect cycle.
  - All counters reset to 0 and wrap at 2^32.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset release, memory always ready, 1-cycle latency, out_ready=1 → requests at 0x0,0x4,0x8,…; out_pc sequence 0x0,0x4,0x8 with matching out_instr; first out_valid 2 cycles after the first handshake.
- out_ready=0, DEPTH=4 → exactly 4 requests issued, occupancy=4, imem_req_valid=0. Then one out_ready pulse → occupancy 3, one new request the next cycle.
- imem_req_ready held 0 for 5 cycles → imem_req_valid=1 with addr stable at 0x10 throughout; no allocation.
- Two requests outstanding (latency 4), redirect to 0x103 → next request at 0x100; two old responses dropped; first out_pc=0x100. With FETCH_QUEUE_STATS_EN, stat_discarded=2 and stat_redirects=1.
- Redirect in the same cycle as a valid response and out_valid&&out_ready → response dropped, no dequeue counted, out_valid=0 next cycle, discard_cnt equals remaining old outstanding.
- Assert reset mid-burst with 3 outstanding → outputs zero immediately (async); after release fetch restarts at RESET_PC and stale responses are ignored by the bench protocol.

Source files
------------

// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: RV32E instruction-fetch queue with variable-latency imem, redirect and response discard.
// Ports: i_clk, i_rst_n (async active-low); i_redirect/i_redirect_pc restart fetch;
//   o_imem_req_valid/i_imem_req_ready/o_imem_req_addr request channel; i_imem_rsp_valid/i_imem_rsp_data in-order responses;
//   o_out_valid/i_out_ready/o_out_pc/o_out_instr head entry to ID; o_occupancy allocated entries.
// Optional: define FETCH_QUEUE_STATS_EN for o_stat_stall_cycles, o_stat_discarded, o_stat_redirects.
module rv_fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_redirect,
  input  logic [XLEN-1:0]          i_redirect_pc,
  output logic                     o_imem_req_valid,
  input  logic                     i_imem_req_ready,
  output logic [XLEN-1:0]          o_imem_req_addr,
  input  logic                     i_imem_rsp_valid,
  input  logic [XLEN-1:0]          i_imem_rsp_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [XLEN-1:0]          o_out_pc,
  output logic [XLEN-1:0]          o_out_instr,
  output logic [$clog2(DEPTH):0]   o_occupancy
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]              o_stat_stall_cycles,
  output logic [31:0]              o_stat_discarded,
  output logic [31:0]              o_stat_redirects
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = AW + 2;
  logic [XLEN-1:0] r_fetch_pc;
  logic [PW-1:0]   r_alloc_ptr, r_fill_ptr, r_head_ptr;
  logic [DW-1:0]   r_discard_cnt;
  logic [XLEN-1:0] r_pc [DEPTH];
  logic [XLEN-1:0] r_instr [DEPTH];
  logic [DEPTH-1:0] r_filled;
  logic [PW-1:0]   w_occ, w_outstanding;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_issue, w_drop, w_pending, w_fill, w_rsp_hit, w_rsp_drop, w_deq;
  logic [DW:0]     w_disc_sum;
  logic [DW-1:0]   w_disc_next;
  assign w_occ         = r_alloc_ptr - r_head_ptr;
  assign w_outstanding = r_alloc_ptr - r_fill_ptr;
  assign w_redirect_pc = i_redirect_pc & ~XLEN'(3);
  // occupancy never exceeds DEPTH, so its MSB alone flags a full queue
  assign o_imem_req_valid = i_rst_n && !i_redirect && !w_occ[PW-1];
  assign o_imem_req_addr  = r_fetch_pc;
  assign w_issue   = o_imem_req_valid && i_imem_req_ready;
  assign w_drop    = r_discard_cnt != '0;
  assign w_pending = w_outstanding != '0;
  assign w_rsp_hit = i_imem_rsp_valid && (w_drop || w_pending);
  assign w_fill    = i_imem_rsp_valid && !w_drop && w_pending && !i_redirect;
  // in a redirect cycle every legitimate response is dropped, either as an old discard or as a now-stale pending one
  assign w_rsp_drop = i_redirect ? w_rsp_hit : i_imem_rsp_valid && w_drop;
  assign w_disc_sum = {1'b0, r_discard_cnt} + (i_redirect ? (DW+1)'(w_outstanding) : '0) - (DW+1)'(w_rsp_drop);
  assign w_disc_next = w_disc_sum > (DW+1)'(2*DEPTH) ? DW'(2*DEPTH) : w_disc_sum[DW-1:0];
  assign o_out_valid = r_filled[r_head_ptr[AW-1:0]] && w_occ != '0 && !i_redirect;
  assign w_deq       = o_out_valid && i_out_ready;
  assign o_out_pc    = r_pc[r_head_ptr[AW-1:0]];
  assign o_out_instr = r_instr[r_head_ptr[AW-1:0]];
  assign o_occupancy = w_occ;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_alloc_ptr   <= '0;
      r_fill_ptr    <= '0;
      r_head_ptr    <= '0;
      r_discard_cnt <= '0;
      r_filled      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else begin
      r_discard_cnt <= w_disc_next;
      if (i_redirect) begin
        r_alloc_ptr <= '0;
        r_fill_ptr  <= '0;
        r_head_ptr  <= '0;
        r_fetch_pc  <= w_redirect_pc;
      end else begin
        // issue and fill never target the same slot: fill needs a pending entry, issue needs a free one
        if (w_issue) begin
          r_pc[r_alloc_ptr[AW-1:0]]     <= r_fetch_pc;
          r_filled[r_alloc_ptr[AW-1:0]] <= 1'b0;
          r_alloc_ptr                   <= r_alloc_ptr + PW'(1);
          r_fetch_pc                    <= r_fetch_pc + XLEN'(4);
        end
        if (w_fill) begin
          r_instr[r_fill_ptr[AW-1:0]]  <= i_imem_rsp_data;
          r_filled[r_fill_ptr[AW-1:0]] <= 1'b1;
          r_fill_ptr                   <= r_fill_ptr + PW'(1);
        end
        if (w_deq) r_head_ptr <= r_head_ptr + PW'(1);
      end
    end
  end
  a_rsp_expected: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_imem_rsp_valid && !w_drop && !w_pending));
  a_discard_sat:  assert property (@(posedge i_clk) disable iff (!i_rst_n) w_disc_sum <= (DW+1)'(2*DEPTH));
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] r_stat_stall, r_stat_disc, r_stat_redir;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stat_stall <= '0;
      r_stat_disc  <= '0;
      r_stat_redir <= '0;
    end else begin
      if (w_occ[PW-1]) r_stat_stall <= r_stat_stall + 32'd1;
      if (w_rsp_drop) r_stat_disc <= r_stat_disc + 32'd1;
      if (i_redirect) r_stat_redir <= r_stat_redir + 32'd1;
    end
  end
  assign o_stat_stall_cycles = r_stat_stall;
  assign o_stat_discarded    = r_stat_disc;
  assign o_stat_redirects    = r_stat_redir;
`endif
endmodule
